dma_axi_wr_arbiter: RTL and testbench
=====================================

Name: dma_axi_wr_arbiter

Overview:
- Shares one AXI4 write master port (toward the HP/interconnect slave) between C_NUM_MASTERS circular DMA engines.
- Each engine issues single-outstanding write bursts: AW, then W beats ending in wlast, then a wait for B.
- The arbiter grants one engine per transaction with round-robin fairness and holds the grant from AW through the B handshake.
- It also flags protocol errors where wlast disagrees with awlen.

Parameters:
- C_NUM_MASTERS, 2, number of requesting engines (2..8).
- C_ADDR_WIDTH, 32, AXI address width.
- C_AXIS_WIDTH, 64, AXI write data width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_mask  in  N  per-engine enable; 0 = engine never granted
- s_awaddr  in  N*C_ADDR_WIDTH  packed, engine i at [i*AW +: AW]
- s_awlen  in  N*8  packed burst lengths
- s_awvalid  in  N ; s_awready  out  N
- s_wdata  in  N*C_AXIS_WIDTH ; s_wlast  in  N ; s_wvalid  in  N ; s_wready  out  N
- s_bresp  out  N*2 ; s_bvalid  out  N ; s_bready  in  N
- m_axi_awaddr  out  C_ADDR_WIDTH ; m_axi_awlen  out  8 ; m_axi_awvalid  out  1 ; m_axi_awready  in  1
- m_axi_wdata  out  C_AXIS_WIDTH ; m_axi_wlast  out  1 ; m_axi_wvalid  out  1 ; m_axi_wready  in  1
- m_axi_bresp  in  2 ; m_axi_bvalid  in  1 ; m_axi_bready  out  1
- grant_idx  out  $clog2(N) max 1  index of the current or last grantee
- busy  out  1  high in every state except ST_IDLE
- len_error  out  1  sticky protocol error flag

Behaviour:
- Reset values: state=ST_IDLE, grant_idx=0, rr pointer=0, len_error=0, beat counter=0. All m_axi valid/ready outputs and all s_* ready/valid outputs are 0.
- Registered: state, grant_idx, rr pointer, beat counter, latched awlen, len_error.
- Combinational: channel muxing, selected by the registered grant_idx and state.
- FSM states:
  - ST_IDLE: request vector = s_awvalid & req_mask. If nonzero, select the first set bit searching upward (with wrap) from rr pointer, register it in grant_idx, and go to ST_ADDR next cycle. No m_axi valid in ST_IDLE, so arbitration latency is 1 cycle.
  - ST_ADDR: m_axi_aw* = granted engine's aw*; s_awready[grant] = m_axi_awready. On handshake, latch awlen, clear the beat counter, go to ST_DATA.
  - ST_DATA: m_axi_w* = granted engine's w*; s_wready[grant] = m_axi_wready. On each beat, the beat counter increments. A beat where s_wlast is set goes to ST_RESP.
    - wlast on beat != awlen+1: set len_error.
    - Beat awlen+1 reached without wlast: set len_error, force m_axi_wlast=1 on that beat, go to ST_RESP. Any further beats from that engine are refused (wready=0).
  - ST_RESP: m_axi_bready = s_bready[grant]; s_bvalid[grant] = m_axi_bvalid; s_bresp[grant] = m_axi_bresp. On handshake, rr pointer = grant_idx+1 (mod N) and go to ST_IDLE.
- Non-granted engines always see awready=wready=bvalid=0 and bresp=0.
- An engine that drops s_awvalid in ST_ADDR is an AXI violation. The arbiter stays in ST_ADDR and does not re-arbitrate.
- Deasserting req_mask during a granted transaction does not abort it; the mask only affects ST_IDLE.
- Back-to-back: after the B handshake, one idle cycle, then the next grant. With all engines requesting, grants rotate 0,1,..,N-1,0.
- Single requester: re-granted every transaction with no extra penalty beyond the idle cycle.
- Beat counter is 9 bits, so awlen=255 gives 256 beats without overflow.
- Mid-transaction reset: all outputs return to reset values the next cycle. Engines are reset by the same rst_n.
- len_error clears only on reset.

Decomposition:
- Shared package dma_arb_pkg holds:
  - enum arb_state_t {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} (logic [1:0]);
  - function/localparam for index width, max(1,$clog2(N)).
- Sub-module rr_arbiter (combinational priority search from pointer):
  - inputs req[N], ptr;
  - outputs gnt_idx, gnt_any.

Test Plan:
- N=2, engine 0 only: awaddr=0x1000_0000, awlen=15, 16 beats, bresp=OKAY -> m_axi sees exactly 16 beats with wlast on beat 16. s_bvalid[0] is pulsed, busy returns to 0, grant_idx=0.
- Both engines request continuously with awlen=3 -> grants alternate 0,1,0,1 over 4 transactions. Exactly 1 idle cycle between each B handshake and the next awvalid.
- req_mask=2'b01 with both requesting -> only engine 0 is granted. s_awready[1] stays 0 for 3 transactions.
- Engine 1, awlen=7, wlast asserted on beat 4 -> len_error=1, transition to ST_RESP after beat 4. The next transaction proceeds normally.
- Slave returns bresp=2'b10 to engine 1 -> s_bresp[1]=2'b10 and s_bvalid[1]=1. s_bvalid[0] is never asserted; the arbiter returns to ST_IDLE.
- Assert rst_n=0 in ST_DATA after beat 5 of 16 with m_axi_wready held high -> the next cycle all valids/readies are 0, state=ST_IDLE and len_error=0.

Source files
------------

// File: rtl/dma_arb_pkg.sv
// Shared types and helpers for the DMA AXI write-channel arbiter.
package dma_arb_pkg;

  // Transaction phases of the shared AXI write port.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } arb_state_t;

  // AXI write response codes.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Width of an engine index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : dma_arb_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first set request at or above ptr,
// wrapping around to the lowest set request when none is found above.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  logic [IW-1:0] hi_idx;
  logic [IW-1:0] lo_idx;
  logic          hi_any;
  logic          lo_any;

  // Scan downward so the last hit written is the lowest matching index.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves it unassigned, which would infer a latch.
    hi_idx = '0;
    lo_idx = '0;
    hi_any = 1'b0;
    lo_any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = IW'(i);
        lo_any = 1'b1;
        if (i >= int'(ptr)) begin
          hi_idx = IW'(i);
          hi_any = 1'b1;
        end
      end
    end
  end

  // Prefer the upward match; fall back to the wrapped (lowest) one.
  always_comb begin
    gnt_any = lo_any;
    gnt_idx = hi_any ? hi_idx : lo_idx;
  end

endmodule : rr_arbiter

// File: rtl/dma_axi_wr_arbiter.sv
// Shares one AXI4 write master port between several circular DMA engines.
// One engine owns the port from its AW handshake through its B handshake;
// ownership rotates round-robin. Bursts whose wlast disagrees with awlen
// raise a sticky len_error, and an over-long burst is cut at awlen+1 beats.
module dma_axi_wr_arbiter
  import dma_arb_pkg::*;
#(
  parameter int C_NUM_MASTERS = 2,
  parameter int C_ADDR_WIDTH  = 32,
  parameter int C_AXIS_WIDTH  = 64
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [C_NUM_MASTERS-1:0]               req_mask,
  // Engine-side AXI write channels, packed per engine
  input  logic [C_NUM_MASTERS*C_ADDR_WIDTH-1:0]  s_awaddr,
  input  logic [C_NUM_MASTERS*8-1:0]             s_awlen,
  input  logic [C_NUM_MASTERS-1:0]               s_awvalid,
  output logic [C_NUM_MASTERS-1:0]               s_awready,
  input  logic [C_NUM_MASTERS*C_AXIS_WIDTH-1:0]  s_wdata,
  input  logic [C_NUM_MASTERS-1:0]               s_wlast,
  input  logic [C_NUM_MASTERS-1:0]               s_wvalid,
  output logic [C_NUM_MASTERS-1:0]               s_wready,
  output logic [C_NUM_MASTERS*2-1:0]             s_bresp,
  output logic [C_NUM_MASTERS-1:0]               s_bvalid,
  input  logic [C_NUM_MASTERS-1:0]               s_bready,
  // Shared AXI write master port
  output logic [C_ADDR_WIDTH-1:0]                m_axi_awaddr,
  output logic [7:0]                             m_axi_awlen,
  output logic                                   m_axi_awvalid,
  input  logic                                   m_axi_awready,
  output logic [C_AXIS_WIDTH-1:0]                m_axi_wdata,
  output logic                                   m_axi_wlast,
  output logic                                   m_axi_wvalid,
  input  logic                                   m_axi_wready,
  input  logic [1:0]                             m_axi_bresp,
  input  logic                                   m_axi_bvalid,
  output logic                                   m_axi_bready,
  // Status
  output logic [idx_width(C_NUM_MASTERS)-1:0]    grant_idx,
  output logic                                   busy,
  output logic                                   len_error
);

  localparam int N  = C_NUM_MASTERS;
  localparam int IW = idx_width(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  arb_state_t    state;
  logic [IW-1:0] rr_ptr;
  logic [8:0]    beat_cnt;
  logic [7:0]    awlen_q;

  logic [IW-1:0] arb_idx;
  logic          arb_any;
  logic [N-1:0]  req_vec;

  logic [C_ADDR_WIDTH-1:0] awaddr_arr [N];
  logic [7:0]              awlen_arr  [N];
  logic [C_AXIS_WIDTH-1:0] wdata_arr  [N];
  logic [1:0]              bresp_arr  [N];

  logic last_beat;
  logic aw_hs;
  logic w_hs;
  logic b_hs;

  // Per-engine views of the packed engine buses.
  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign awaddr_arr[i]     = s_awaddr[i*C_ADDR_WIDTH +: C_ADDR_WIDTH];
    assign awlen_arr[i]      = s_awlen[i*8 +: 8];
    assign wdata_arr[i]      = s_wdata[i*C_AXIS_WIDTH +: C_AXIS_WIDTH];
    assign s_bresp[i*2 +: 2] = bresp_arr[i];
  end

  // Only engines that are enabled and presenting an address compete.
  assign req_vec = s_awvalid & req_mask;

  rr_arbiter #(
    .N  (N),
    .IW (IW)
  ) u_rr_arbiter (
    .req     (req_vec),
    .ptr     (rr_ptr),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  // The beat being presented is number awlen+1, i.e. the last legal one.
  assign last_beat = (beat_cnt == {1'b0, awlen_q});

  assign aw_hs = (state == ST_ADDR) && s_awvalid[grant_idx] && m_axi_awready;
  assign w_hs  = (state == ST_DATA) && s_wvalid[grant_idx]  && m_axi_wready;
  assign b_hs  = (state == ST_RESP) && m_axi_bvalid && s_bready[grant_idx];

  assign busy = (state != ST_IDLE);

  // Route exactly one channel of the granted engine to the master port.
  always_comb begin
    m_axi_awaddr  = '0;
    m_axi_awlen   = '0;
    m_axi_awvalid = 1'b0;
    m_axi_wdata   = '0;
    m_axi_wlast   = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    s_awready     = '0;
    s_wready      = '0;
    s_bvalid      = '0;
    for (int i = 0; i < N; i++) bresp_arr[i] = '0;
    case (state)
      ST_ADDR: begin
        m_axi_awaddr         = awaddr_arr[grant_idx];
        m_axi_awlen          = awlen_arr[grant_idx];
        m_axi_awvalid        = s_awvalid[grant_idx];
        s_awready[grant_idx] = m_axi_awready;
      end
      ST_DATA: begin
        m_axi_wdata         = wdata_arr[grant_idx];
        m_axi_wvalid        = s_wvalid[grant_idx];
        // Terminate the burst at awlen+1 even if the engine forgot wlast.
        m_axi_wlast         = s_wlast[grant_idx] | last_beat;
        s_wready[grant_idx] = m_axi_wready;
      end
      ST_RESP: begin
        m_axi_bready         = s_bready[grant_idx];
        s_bvalid[grant_idx]  = m_axi_bvalid;
        bresp_arr[grant_idx] = m_axi_bresp;
      end
      default: ;
    endcase
  end

  // Transaction FSM: arbitrate, pass AW, count W beats, pass B, rotate.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so each one samples the pre-edge value of every other.
    if (!rst_n) begin
      state     <= ST_IDLE;
      grant_idx <= '0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      awlen_q   <= '0;
      len_error <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            grant_idx <= arb_idx;
            state     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          // A dropped awvalid simply stalls here; the grant is kept.
          if (aw_hs) begin
            awlen_q  <= awlen_arr[grant_idx];
            beat_cnt <= '0;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_hs) begin
            beat_cnt <= beat_cnt + 9'd1;
            // Early wlast or missing wlast on the final beat are both errors.
            if (s_wlast[grant_idx] != last_beat) len_error <= 1'b1;
            if (s_wlast[grant_idx] || last_beat) state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (b_hs) begin
            rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule : dma_axi_wr_arbiter

// File: tb/tb_dma_axi_wr_arbiter.sv
// Bench for dma_axi_wr_arbiter: behavioural engines and a behavioural AXI
// slave exchange handshakes cycle by cycle; a monitor rebuilds each master
// side transaction and compares it against a directed vector table, followed
// by hand-written round-robin, masking, and mid-burst reset sequences.
module tb_dma_axi_wr_arbiter;
  import dma_arb_pkg::*;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = idx_width(N);

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req_mask;
  logic [N*AW-1:0]   s_awaddr;
  logic [N*8-1:0]    s_awlen;
  logic [N-1:0]      s_awvalid, s_awready;
  logic [N*DW-1:0]   s_wdata;
  logic [N-1:0]      s_wlast, s_wvalid, s_wready;
  logic [N*2-1:0]    s_bresp;
  logic [N-1:0]      s_bvalid, s_bready;
  logic [AW-1:0]     m_axi_awaddr;
  logic [7:0]        m_axi_awlen;
  logic              m_axi_awvalid, m_axi_awready;
  logic [DW-1:0]     m_axi_wdata;
  logic              m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [1:0]        m_axi_bresp;
  logic              m_axi_bvalid, m_axi_bready;
  logic [IW-1:0]     grant_idx;
  logic              busy;
  logic              len_error;

  dma_axi_wr_arbiter #(
    .C_NUM_MASTERS (N),
    .C_ADDR_WIDTH  (AW),
    .C_AXIS_WIDTH  (DW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_mask      (req_mask),
    .s_awaddr      (s_awaddr),
    .s_awlen       (s_awlen),
    .s_awvalid     (s_awvalid),
    .s_awready     (s_awready),
    .s_wdata       (s_wdata),
    .s_wlast       (s_wlast),
    .s_wvalid      (s_wvalid),
    .s_wready      (s_wready),
    .s_bresp       (s_bresp),
    .s_bvalid      (s_bvalid),
    .s_bready      (s_bready),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awlen   (m_axi_awlen),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wlast   (m_axi_wlast),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .grant_idx     (grant_idx),
    .busy          (busy),
    .len_error     (len_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks;
  int errors;
  int cycle;
  int last_b_cycle;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // ---------------- engine and slave models ----------------
  typedef enum logic [1:0] {E_IDLE, E_AW, E_W, E_B} eng_ph_t;
  typedef enum logic [1:0] {S_AW, S_W, S_B} sl_ph_t;

  eng_ph_t     e_ph        [N];
  int          e_txn_left  [N];
  logic [31:0] e_addr      [N];
  logic [7:0]  e_len       [N];
  int          e_wlast_beat[N];
  int          e_beat      [N];
  int          aw_rdy_seen [N];
  int          bv_seen     [N];

  sl_ph_t      sl_ph;
  logic [1:0]  sl_bresp;

  typedef struct {
    int          grant;
    logic [31:0] addr;
    logic [7:0]  len;
    int          beats;
    int          wlast_beat;
    int          b_eng;
    logic [1:0]  b_resp;
    int          gap;
  } rec_t;

  rec_t rec_q[$];
  rec_t cur;
  rec_t r;

  task automatic reset_models();
    for (int i = 0; i < N; i++) begin
      e_ph[i]         = E_IDLE;
      e_txn_left[i]   = 0;
      e_addr[i]       = '0;
      e_len[i]        = '0;
      e_wlast_beat[i] = 0;
      e_beat[i]       = 0;
    end
    sl_ph = S_AW;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      s_awaddr[i*AW +: AW] = e_addr[i];
      s_awlen[i*8 +: 8]    = e_len[i];
      s_awvalid[i]         = (e_ph[i] == E_AW);
      s_wvalid[i]          = (e_ph[i] == E_W);
      s_wlast[i]           = (e_ph[i] == E_W) && (e_beat[i] + 1 == e_wlast_beat[i]);
      s_wdata[i*DW +: DW]  = {e_addr[i], 32'(e_beat[i])};
      s_bready[i]          = (e_ph[i] == E_W) || (e_ph[i] == E_B);
    end
    m_axi_awready = (sl_ph == S_AW);
    m_axi_wready  = (sl_ph == S_W);
    m_axi_bvalid  = (sl_ph == S_B);
    m_axi_bresp   = (sl_ph == S_B) ? sl_bresp : 2'b00;
  endtask

  task automatic start_engine(input int i, input logic [31:0] addr, input logic [7:0] len,
                              input int wlast_beat, input int ntxn);
    e_addr[i]       = addr;
    e_len[i]        = len;
    e_wlast_beat[i] = wlast_beat;
    e_txn_left[i]   = ntxn;
    e_beat[i]       = 0;
    e_ph[i]         = E_AW;
    drive();
  endtask

  task automatic clear_seen();
    for (int i = 0; i < N; i++) begin
      aw_rdy_seen[i] = 0;
      bv_seen[i]     = 0;
    end
  endtask

  // One clock: sample at the falling edge, advance models just after the rising edge.
  task automatic step();
    logic [N-1:0] aw_hs, w_hs, b_hs, other, iso_bad;
    logic         bresp_bad, m_aw_hs, m_w_hs, m_wl, m_b_hs;
    logic [63:0]  exp_wdata;
    @(negedge clk);
    cycle++;
    other = '1;
    other[grant_idx] = 1'b0;
    iso_bad = (s_awready | s_wready | s_bvalid) & other;
    bresp_bad = 1'b0;
    for (int i = 0; i < N; i++)
      if (other[i] && s_bresp[i*2 +: 2] != 2'b00) bresp_bad = 1'b1;
    check("non_grant_isolation", {iso_bad, bresp_bad}, '0);

    aw_hs = s_awvalid & s_awready;
    w_hs  = s_wvalid & s_wready;
    b_hs  = s_bvalid & s_bready;
    for (int i = 0; i < N; i++) begin
      if (s_awready[i]) aw_rdy_seen[i]++;
      if (s_bvalid[i])  bv_seen[i]++;
    end
    m_aw_hs = m_axi_awvalid & m_axi_awready;
    m_w_hs  = m_axi_wvalid & m_axi_wready;
    m_wl    = m_axi_wlast;
    m_b_hs  = m_axi_bvalid & m_axi_bready;

    if (m_aw_hs) begin
      cur.grant      = int'(grant_idx);
      cur.addr       = m_axi_awaddr;
      cur.len        = m_axi_awlen;
      cur.beats      = 0;
      cur.wlast_beat = 0;
      cur.b_eng      = -1;
      cur.b_resp     = 2'b00;
      cur.gap        = cycle - last_b_cycle;
    end
    if (m_w_hs) begin
      exp_wdata = '0;
      for (int i = 0; i < N; i++)
        if (e_ph[i] == E_W) exp_wdata = {e_addr[i], 32'(e_beat[i])};
      check("wdata_route", m_axi_wdata, exp_wdata);
      cur.beats++;
      if (m_wl && cur.wlast_beat == 0) cur.wlast_beat = cur.beats;
    end
    for (int i = 0; i < N; i++)
      if (b_hs[i]) begin
        cur.b_eng  = i;
        cur.b_resp = s_bresp[i*2 +: 2];
      end
    if (m_b_hs) begin
      rec_q.push_back(cur);
      last_b_cycle = cycle;
    end

    @(posedge clk);
    #1;
    if (!rst_n) begin
      reset_models();
    end else begin
      for (int i = 0; i < N; i++) begin
        case (e_ph[i])
          E_AW: if (aw_hs[i]) begin
            e_ph[i]   = E_W;
            e_beat[i] = 0;
          end
          E_W, E_B: begin
            if (b_hs[i]) begin
              e_txn_left[i]--;
              e_ph[i] = (e_txn_left[i] > 0) ? E_AW : E_IDLE;
            end else if (e_ph[i] == E_W && w_hs[i]) begin
              e_beat[i]++;
              if (e_beat[i] == e_wlast_beat[i]) e_ph[i] = E_B;
            end
          end
          default: ;
        endcase
      end
      case (sl_ph)
        S_AW:    if (m_aw_hs) sl_ph = S_W;
        S_W:     if (m_w_hs && m_wl) sl_ph = S_B;
        S_B:     if (m_b_hs) sl_ph = S_AW;
        default: sl_ph = S_AW;
      endcase
    end
    drive();
  endtask

  task automatic wait_records(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (rec_q.size() < n && k < budget) begin
      step();
      k++;
    end
    check(name, 64'(rec_q.size() >= n), 64'd1);
  endtask

  task automatic do_reset(input int ncyc);
    rst_n = 1'b0;
    repeat (ncyc) step();
    rst_n = 1'b1;
  endtask

  // ---------------- directed single-transaction vectors ----------------
  typedef struct {
    int          eng;
    logic [1:0]  mask;
    logic [31:0] addr;
    logic [7:0]  len;
    int          wlast_beat;
    logic [1:0]  bresp;
    int          exp_beats;
    int          exp_wlast_beat;
    logic        exp_len_error;
  } vec_t;

  vec_t vecs[7];

  initial begin
    checks       = 0;
    errors       = 0;
    cycle        = 0;
    last_b_cycle = 0;
    req_mask     = '0;
    sl_bresp     = RESP_OKAY;
    rst_n        = 1'b0;
    clear_seen();
    reset_models();
    drive();

    //          eng mask   addr           len    wlast bresp        beats wl  err
    vecs[0] = '{0, 2'b11, 32'h1000_0000, 8'd15,  16,  RESP_OKAY,   16,  16, 1'b0};
    vecs[1] = '{1, 2'b11, 32'h2000_0040, 8'd7,   4,   RESP_OKAY,   4,   4,  1'b1};
    vecs[2] = '{1, 2'b11, 32'h2000_0080, 8'd3,   4,   RESP_OKAY,   4,   4,  1'b1};
    vecs[3] = '{1, 2'b10, 32'h3000_0000, 8'd1,   2,   RESP_SLVERR, 2,   2,  1'b1};
    vecs[4] = '{0, 2'b01, 32'h1000_0100, 8'd3,   6,   RESP_OKAY,   4,   4,  1'b1};
    vecs[5] = '{0, 2'b11, 32'h0000_0000, 8'd0,   1,   RESP_EXOKAY, 1,   1,  1'b1};
    vecs[6] = '{1, 2'b11, 32'hFFFF_F000, 8'd255, 256, RESP_OKAY,   256, 256, 1'b1};

    // Reset state
    do_reset(3);
    check("rst_busy",      64'(busy),          64'd0);
    check("rst_grant_idx", 64'(grant_idx),     64'd0);
    check("rst_len_error", 64'(len_error),     64'd0);
    check("rst_m_valids",  64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 64'd0);
    check("rst_s_readys",  64'({s_awready, s_wready, s_bvalid}), 64'd0);

    // Table-driven single transactions
    for (int v = 0; v < 7; v++) begin
      clear_seen();
      req_mask = vecs[v].mask;
      sl_bresp = vecs[v].bresp;
      start_engine(vecs[v].eng, vecs[v].addr, vecs[v].len, vecs[v].wlast_beat, 1);
      wait_records(1, 600, $sformatf("v%0d_complete", v));
      if (rec_q.size() > 0) begin
        r = rec_q.pop_front();
        check($sformatf("v%0d_grant", v),      64'(r.grant),      64'(vecs[v].eng));
        check($sformatf("v%0d_awaddr", v),     64'(r.addr),       64'(vecs[v].addr));
        check($sformatf("v%0d_awlen", v),      64'(r.len),        64'(vecs[v].len));
        check($sformatf("v%0d_beats", v),      64'(r.beats),      64'(vecs[v].exp_beats));
        check($sformatf("v%0d_wlast_beat", v), 64'(r.wlast_beat), 64'(vecs[v].exp_wlast_beat));
        check($sformatf("v%0d_b_engine", v),   64'(r.b_eng),      64'(vecs[v].eng));
        check($sformatf("v%0d_bresp", v),      64'(r.b_resp),     64'(vecs[v].bresp));
      end
      step();
      check($sformatf("v%0d_busy_after", v),   64'(busy),      64'd0);
      check($sformatf("v%0d_grant_idx", v),    64'(grant_idx), 64'(vecs[v].eng));
      check($sformatf("v%0d_len_error", v),    64'(len_error), 64'(vecs[v].exp_len_error));
      check($sformatf("v%0d_bvalid_pulse", v), 64'(bv_seen[vecs[v].eng]),     64'd1);
      check($sformatf("v%0d_other_bvalid", v), 64'(bv_seen[1 - vecs[v].eng]), 64'd0);
      check($sformatf("v%0d_other_awrdy", v),  64'(aw_rdy_seen[1 - vecs[v].eng]), 64'd0);
    end

    // Round robin: both engines request continuously, two bursts each
    do_reset(2);
    check("rr_len_error_cleared", 64'(len_error), 64'd0);
    rec_q.delete();
    req_mask = 2'b11;
    sl_bresp = RESP_OKAY;
    start_engine(0, 32'h4000_0000, 8'd3, 4, 2);
    start_engine(1, 32'h5000_0000, 8'd3, 4, 2);
    wait_records(4, 400, "rr_complete");
    for (int k = 0; k < 4 && rec_q.size() > 0; k++) begin
      r = rec_q.pop_front();
      check($sformatf("rr%0d_grant", k), 64'(r.grant), 64'(k % 2));
      check($sformatf("rr%0d_beats", k), 64'(r.beats), 64'd4);
      if (k > 0) check($sformatf("rr%0d_b_to_aw_gap", k), 64'(r.gap), 64'd2);
    end
    step();
    check("rr_busy_after", 64'(busy), 64'd0);

    // Mask: engine 1 requests but is disabled; engine 0 gets three bursts
    clear_seen();
    req_mask = 2'b01;
    start_engine(0, 32'h6000_0000, 8'd3, 4, 3);
    start_engine(1, 32'h7000_0000, 8'd3, 4, 1);
    wait_records(3, 300, "mask_complete");
    for (int k = 0; k < 3 && rec_q.size() > 0; k++) begin
      r = rec_q.pop_front();
      check($sformatf("mask%0d_grant", k), 64'(r.grant), 64'd0);
    end
    repeat (3) step();
    check("mask_awready1_never", 64'(aw_rdy_seen[1]), 64'd0);
    check("mask_idle_busy",      64'(busy),           64'd0);
    // Unmask, then drop the mask mid-transaction: the burst must still finish
    req_mask = 2'b11;
    for (int k = 0; k < 20 && e_ph[1] != E_W; k++) step();
    check("unmask_granted", 64'(e_ph[1] == E_W), 64'd1);
    req_mask = 2'b00;
    wait_records(1, 100, "unmask_complete");
    if (rec_q.size() > 0) begin
      r = rec_q.pop_front();
      check("unmask_grant",  64'(r.grant), 64'd1);
      check("unmask_beats",  64'(r.beats), 64'd4);
      check("unmask_b_eng",  64'(r.b_eng), 64'd1);
    end

    // Mid-burst reset: set len_error first, then reset after beat 5 of 16
    req_mask = 2'b11;
    start_engine(1, 32'h8000_0000, 8'd1, 1, 1);
    wait_records(1, 100, "pre_reset_err_complete");
    if (rec_q.size() > 0) r = rec_q.pop_front();
    step();
    check("pre_reset_len_error", 64'(len_error), 64'd1);
    start_engine(1, 32'h8000_1000, 8'd15, 16, 1);
    for (int k = 0; k < 60 && !(e_ph[1] == E_W && e_beat[1] == 5); k++) step();
    check("mid_burst_reached", 64'(e_beat[1]), 64'd5);
    check("mid_burst_busy",    64'(busy),      64'd1);
    rst_n = 1'b0;
    step();
    check("mrst_busy",      64'(busy),      64'd0);
    check("mrst_grant_idx", 64'(grant_idx), 64'd0);
    check("mrst_len_error", 64'(len_error), 64'd0);
    check("mrst_m_valids",  64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 64'd0);
    check("mrst_s_readys",  64'({s_awready, s_wready, s_bvalid}), 64'd0);
    rst_n = 1'b1;
    step();
    check("mrst_no_record", 64'(rec_q.size()), 64'd0);

    // Recovery: a normal single-beat burst after reset
    start_engine(0, 32'h9000_0000, 8'd0, 1, 1);
    wait_records(1, 100, "recover_complete");
    if (rec_q.size() > 0) begin
      r = rec_q.pop_front();
      check("recover_grant", 64'(r.grant), 64'd0);
      check("recover_beats", 64'(r.beats), 64'd1);
    end
    step();
    check("recover_len_error", 64'(len_error), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_dma_axi_wr_arbiter
